mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: default widths,
// FSM state encoding and a small index-to-one-hot helper.
package mem_arbiter_pkg;

  // Default memory geometry used when the top is instantiated without overrides.
  localparam int ARB_ADDR_W = 5;
  localparam int ARB_DATA_W = 16;

  // Arbiter FSM. Every granted transaction walks ACCESS -> CAPTURE -> ACK
  // unconditionally, which gives the fixed three-cycle request-to-ack latency.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_e;

  // Turn a requester index into its one-hot grant/ack vector.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin winner selection. Purely combinational.
// A lone requester always wins; on contention the requester named by prio
// wins. next_prio always points at the loser so that the other side is
// favoured on the next contended grant. When req is zero the outputs are
// don't-care; the caller only consumes them while some request is pending.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       next_prio
);

  // Pick the winner and hand priority to the non-winner.
  always_comb begin
    winner = prio;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = prio;
    endcase
    next_prio = ~winner;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
//
// Handshake: a requester raises req[i] together with we[i], addr and wdata
// and keeps them stable until it sees ack[i] (a one-cycle pulse). The
// transaction is captured in the IDLE cycle in which it wins, so later
// changes to the request inputs, including dropping req early, do not
// affect it. A req still high in the IDLE cycle after ack is a new
// transaction. Reset (async, active-high) discards any transaction in
// flight without an ack.
//
// Timeline for a request sampled in IDLE at cycle N:
//   N+1 ACCESS  : mem_rd / mem_wr strobe, mem_addr / mem_wdata driven
//   N+2 CAPTURE : mem_rdata (valid the cycle after mem_rd) loaded into rdata
//   N+3 ACK     : ack[owner] pulses, rdata valid for a read
//   N+4 IDLE    : next arbitration
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  arb_state_e state;
  logic       prio;      // requester favoured on the next contended grant
  logic       owner_q;   // index of the current transaction owner
  logic       we_q;      // direction of the current transaction

  logic              winner;
  logic              next_prio;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req       (req),
    .prio      (prio),
    .winner    (winner),
    .next_prio (next_prio)
  );

  // Route the winning requester's fields toward the capture registers.
  always_comb begin
    sel_we    = we[0];
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (winner) begin
      sel_we    = we[1];
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Arbiter FSM with registered outputs. mem_addr / mem_wdata double as the
  // registered address and write data: they are loaded at grant, presented
  // during ACCESS only, and cleared once the strobe has been issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      gnt       <= 2'b00;
      ack       <= 2'b00;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 2'b00;
          if (req != 2'b00) begin
            state     <= ACCESS;
            owner_q   <= winner;
            we_q      <= sel_we;
            prio      <= next_prio;
            gnt       <= idx_to_onehot(winner);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_rd    <= ~sel_we;
            mem_wr    <= sel_we;
          end
        end
        ACCESS: begin
          state     <= CAPTURE;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
        end
        CAPTURE: begin
          state <= ACK;
          ack   <= idx_to_onehot(owner_q);
          if (!we_q) begin
            rdata <= mem_rdata;
          end
        end
        ACK: begin
          state <= IDLE;
          ack   <= 2'b00;
          gnt   <= 2'b00;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Busy whenever a transaction is in flight.
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous memory model, per-scenario tasks with
// inline checks, and a scoreboard that matches every ack against the
// transaction expected to complete next.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW  = 5;
  localparam int DW  = 16;
  localparam int SBW = 2 + 1 + DW;  // {ack, is_read, read data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT ----------------
  logic [1:0]    req, we, gnt, ack, state_dbg;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  // ---------------- scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk) begin
    logic [SBW-1:0] e;
    if (rst === 1'b0 && ack !== 2'b00) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_ack: ack=%b with nothing outstanding", ack);
      end else begin
        e = exp_q.pop_front();
        if (ack !== e[SBW-1 -: 2] || (e[DW] && rdata !== e[DW-1:0])) begin
          n_err++;
          $display("FAIL sb_ack: ack=%b rdata=%h, expected ack=%b rdata=%h (read=%b)",
                   ack, rdata, e[SBW-1 -: 2], e[DW-1:0], e[DW]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    req = 2'b00; we = 2'b00;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait (bounded) for any ack; got stays 0 if the budget runs out.
  task automatic wait_ack(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      tick();
      if (ack !== 2'b00) got = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 2'b00 || ack !== 2'b00 || busy !== 1'b0 || mem_rd !== 1'b0 ||
        mem_wr !== 1'b0 || rdata !== '0 || mem_addr !== '0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: gnt=%b ack=%b busy=%b rd=%b wr=%b rdata=%h addr=%0d st=%0d, need all zero",
               gnt, ack, busy, mem_rd, mem_wr, rdata, mem_addr, state_dbg);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int c0;
    c0 = cyc_cnt;
    req = 2'b01; we = 2'b00; addr0 = 5;
    exp_q.push_back({2'b01, 1'b1, 16'h1234});
    tick();  // cycle 1: ACCESS
    n_cmp++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 5 || gnt !== 2'b01 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL read_access: rd=%b wr=%b addr=%0d gnt=%b busy=%b, need 1 0 5 01 1",
               mem_rd, mem_wr, mem_addr, gnt, busy);
    end
    tick();  // cycle 2: CAPTURE
    n_cmp++;
    if (mem_rd !== 1'b0 || mem_addr !== 0 || gnt !== 2'b01 || ack !== 2'b00 || state_dbg !== CAPTURE) begin
      n_err++;
      $display("FAIL read_capture: rd=%b addr=%0d gnt=%b ack=%b st=%0d, need 0 0 01 00 2",
               mem_rd, mem_addr, gnt, ack, state_dbg);
    end
    tick();  // cycle 3: ACK
    n_cmp++;
    if (ack !== 2'b01 || rdata !== 16'h1234 || cyc_cnt - c0 != 3) begin
      n_err++;
      $display("FAIL read_ack: ack=%b rdata=%h latency=%0d, need 01 1234 3", ack, rdata, cyc_cnt - c0);
    end
    req = 2'b00;
    tick();  // cycle 4: IDLE
    n_cmp++;
    if (gnt !== 2'b00 || ack !== 2'b00 || busy !== 1'b0 || rdata !== 16'h1234) begin
      n_err++;
      $display("FAIL read_idle: gnt=%b ack=%b busy=%b rdata=%h, need 00 00 0 1234", gnt, ack, busy, rdata);
    end
  endtask

  task automatic test_single_write();
    bit got;
    req = 2'b10; we = 2'b10; addr1 = 3; wdata1 = 16'hBEEF;
    exp_q.push_back({2'b10, 1'b0, 16'h0000});
    tick();  // ACCESS
    n_cmp++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 3 || mem_wdata !== 16'hBEEF || gnt !== 2'b10) begin
      n_err++;
      $display("FAIL write_access: wr=%b rd=%b addr=%0d wdata=%h gnt=%b, need 1 0 3 beef 10",
               mem_wr, mem_rd, mem_addr, mem_wdata, gnt);
    end
    tick();  // CAPTURE
    n_cmp++;
    if (mem_wr !== 1'b0 || mem_wdata !== '0) begin
      n_err++;
      $display("FAIL write_strobe_len: wr=%b wdata=%h, need 0 0000", mem_wr, mem_wdata);
    end
    tick();  // ACK
    n_cmp++;
    if (ack !== 2'b10 || rdata !== 16'h1234) begin
      n_err++;
      $display("FAIL write_ack: ack=%b rdata=%h, need 10 1234 (rdata held)", ack, rdata);
    end
    req = 2'b00; we = 2'b00;
    tick();
    // readback by requester 0
    req = 2'b01; addr0 = 3;
    exp_q.push_back({2'b01, 1'b1, 16'hBEEF});
    wait_ack(6, got);
    n_cmp++;
    if (!got || ack !== 2'b01 || rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL write_readback: got=%b ack=%b rdata=%h, need 1 01 beef", got, ack, rdata);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_contention();
    bit got;
    int c0, last, n0, n1;
    logic [1:0] exp_ack;
    do_reset();
    n0 = 0; n1 = 0;
    c0 = cyc_cnt; last = cyc_cnt;
    req = 2'b11; we = 2'b00; addr0 = 1; addr1 = 2;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) exp_q.push_back({2'b01, 1'b1, 16'h1111});
      else            exp_q.push_back({2'b10, 1'b1, 16'h2222});
    end
    for (int k = 0; k < 8; k++) begin
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(6, got);
      n_cmp++;
      if (!got || ack !== exp_ack || cyc_cnt - last != ((k == 0) ? 3 : 4)) begin
        n_err++;
        $display("FAIL contention_%0d: got=%b ack=%b gap=%0d, need 1 %b %0d",
                 k, got, ack, cyc_cnt - last, exp_ack, (k == 0) ? 3 : 4);
      end
      if (ack === 2'b01) n0++;
      if (ack === 2'b10) n1++;
      last = cyc_cnt;
      if (!got) break;
    end
    req = 2'b00;
    tick(); tick();
    n_cmp++;
    if (n0 != 4 || n1 != 4 || cyc_cnt - c0 < 32) begin
      n_err++;
      $display("FAIL contention_fair: n0=%0d n1=%0d, need 4 4", n0, n1);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [1:0] seq [3];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01;
    do_reset();
    req = 2'b01; we = 2'b00; addr0 = 1; addr1 = 2;
    exp_q.push_back({2'b01, 1'b1, 16'h1111});
    exp_q.push_back({2'b10, 1'b1, 16'h2222});
    exp_q.push_back({2'b01, 1'b1, 16'h1111});
    tick();  // ACCESS of requester 0; requester 1 arrives mid-transaction
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_ack(6, got);
      n_cmp++;
      if (!got || ack !== seq[k]) begin
        n_err++;
        $display("FAIL back_to_back_%0d: got=%b ack=%b, need 1 %b", k, got, ack, seq[k]);
      end
      if (!got) break;
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    bit got;
    // requester 0 won last, so prio currently favours requester 1
    req = 2'b01; we = 2'b00; addr0 = 5;
    tick();  // ACCESS
    tick();  // CAPTURE
    rst = 1'b1;
    req = 2'b00;
    #1;
    n_cmp++;
    if (gnt !== 2'b00 || ack !== 2'b00 || busy !== 1'b0 || mem_rd !== 1'b0 ||
        mem_wr !== 1'b0 || rdata !== '0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset_mid: gnt=%b ack=%b busy=%b rd=%b wr=%b rdata=%h st=%0d, need all zero",
               gnt, ack, busy, mem_rd, mem_wr, rdata, state_dbg);
    end
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    n_cmp++;
    if (ack !== 2'b00 || gnt !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_no_ack: ack=%b gnt=%b, need 00 00", ack, gnt);
    end
    req = 2'b11; addr0 = 1; addr1 = 2;
    exp_q.push_back({2'b01, 1'b1, 16'h1111});
    exp_q.push_back({2'b10, 1'b1, 16'h2222});
    wait_ack(6, got);
    n_cmp++;
    if (!got || ack !== 2'b01 || rdata !== 16'h1111) begin
      n_err++;
      $display("FAIL reset_prio: got=%b ack=%b rdata=%h, need 1 01 1111", got, ack, rdata);
    end
    req = 2'b10;
    wait_ack(6, got);
    n_cmp++;
    if (!got || ack !== 2'b10 || rdata !== 16'h2222) begin
      n_err++;
      $display("FAIL reset_second: got=%b ack=%b rdata=%h, need 1 10 2222", got, ack, rdata);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_input_change();
    bit got;
    req = 2'b01; we = 2'b00; addr0 = 5;
    exp_q.push_back({2'b01, 1'b1, 16'h1234});
    tick();  // ACCESS
    n_cmp++;
    if (mem_addr !== 5 || mem_rd !== 1'b1) begin
      n_err++;
      $display("FAIL change_access: addr=%0d rd=%b, need 5 1", mem_addr, mem_rd);
    end
    addr0 = 9; we = 2'b01; wdata0 = 16'hFFFF;
    tick();  // CAPTURE
    n_cmp++;
    if (mem_wr !== 1'b0 || mem_addr !== 0) begin
      n_err++;
      $display("FAIL change_ignored: wr=%b addr=%0d, need 0 0", mem_wr, mem_addr);
    end
    tick();  // ACK
    n_cmp++;
    if (ack !== 2'b01 || rdata !== 16'h1234) begin
      n_err++;
      $display("FAIL change_rdata: ack=%b rdata=%h, need 01 1234", ack, rdata);
    end
    req = 2'b00; we = 2'b00;
    tick();
    // requester 1 writes, then drops req before ack
    req = 2'b10; we = 2'b10; addr1 = 7; wdata1 = 16'h0A0A;
    exp_q.push_back({2'b10, 1'b0, 16'h0000});
    tick();
    req = 2'b00; we = 2'b00;
    wait_ack(5, got);
    n_cmp++;
    if (!got || ack !== 2'b10) begin
      n_err++;
      $display("FAIL drop_req_ack: got=%b ack=%b, need 1 10", got, ack);
    end
    tick();
    req = 2'b01; addr0 = 7;
    exp_q.push_back({2'b01, 1'b1, 16'h0A0A});
    wait_ack(6, got);
    n_cmp++;
    if (!got || rdata !== 16'h0A0A) begin
      n_err++;
      $display("FAIL drop_req_data: got=%b rdata=%h, need 1 0a0a", got, rdata);
    end
    req = 2'b00;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    preload(5'd1, 16'h1111);
    preload(5'd2, 16'h2222);
    preload(5'd5, 16'h1234);
    preload(5'd9, 16'h9999);
    preload(5'd3, 16'h0000);
    preload(5'd7, 16'h0000);
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected acks never seen, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
